// File: rtl/data_mem_bist_pkg.sv
// Shared types for the data memory march self-test.
// States, word type and the per-address data generator.
package data_mem_bist_pkg;

  localparam int DW = 16;

  typedef logic [DW-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_P = 3'd1,
    S_RD_P = 3'd2,
    S_WR_N = 3'd3,
    S_RD_N = 3'd4,
    S_DONE = 3'd5
  } bist_state_t;

  localparam word_t ERR_MAX = '1;

  function automatic word_t gen_word(
    input word_t pattern,
    input word_t addr,
    input logic  inv
  );
    return (pattern ^ addr) ^ {DW{inv}};
  endfunction

endpackage

// File: rtl/data_mem_bist_addr_gen.sv
// Loadable up/down word address counter for the march.
// last flags the final word of the current phase.
module data_mem_bist_addr_gen
  import data_mem_bist_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t load_val,
  input  logic  inc,
  input  logic  dec,
  input  word_t stop_val,
  output word_t addr,
  output logic  last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (inc) begin
      addr <= addr + 16'd1;
    end else if (dec) begin
      addr <= addr - 16'd1;
    end
  end

  assign last = (addr == stop_val);

endmodule

// File: rtl/data_mem_bist.sv
// March self-test initiator for Data_Memory:
// write P, read P, write ~P, read ~P (descending).
module data_mem_bist
  import data_mem_bist_pkg::*;
#(
  parameter word_t BASE    = 16'h0000,
  parameter int    DEPTH   = 256,
  parameter word_t PATTERN = 16'hF0F0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_fail_addr,
  output logic [15:0] first_fail_data,
  output logic [15:0] address,
  output logic [15:0] write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [15:0] read_data_mem
);

  localparam word_t LAST_ADDR = BASE + word_t'(DEPTH - 1);

  bist_state_t state;
  logic  rd_second;
  word_t addr;
  logic  last;
  logic  ag_load;
  logic  ag_inc;
  logic  ag_dec;
  word_t ag_load_val;
  word_t ag_stop;
  logic  inv;
  logic  is_wr;
  logic  is_rd;
  logic  kill;
  logic  step;
  logic  cmp;
  word_t exp_word;

  assign is_wr = (state == S_WR_P) || (state == S_WR_N);
  assign is_rd = (state == S_RD_P) || (state == S_RD_N);
  assign inv   = (state == S_WR_N) || (state == S_RD_N);
  assign kill  = abort && (state != S_IDLE);
  assign step  = !kill && (is_wr || (is_rd && rd_second));
  assign cmp   = is_rd && rd_second && !abort;

  assign exp_word   = gen_word(PATTERN, addr, inv);
  assign address    = addr;
  assign write_data = MemWrite ? exp_word : '0;

  always_comb begin
    ag_load     = 1'b0;
    ag_load_val = BASE;
    ag_inc      = 1'b0;
    ag_dec      = 1'b0;
    ag_stop     = (state == S_RD_N) ? BASE : LAST_ADDR;
    if (state == S_IDLE && start) begin
      ag_load = 1'b1;
    end else if (step) begin
      if (last) begin
        ag_load = 1'b1;
        if (state == S_WR_N) ag_load_val = LAST_ADDR;
      end else if (state == S_RD_N) begin
        ag_dec = 1'b1;
      end else begin
        ag_inc = 1'b1;
      end
    end
  end

  data_mem_bist_addr_gen u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .load_val (ag_load_val),
    .inc      (ag_inc),
    .dec      (ag_dec),
    .stop_val (ag_stop),
    .addr     (addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      rd_second       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      MemWrite        <= 1'b0;
      MemRead         <= 1'b0;
    end else if (kill) begin
      state     <= S_IDLE;
      rd_second <= 1'b0;
      busy      <= 1'b0;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
    end else begin
      if (cmp && (read_data_mem != exp_word)) begin
        if (err_count != ERR_MAX) err_count <= err_count + 16'd1;
        if (err_count == '0) begin
          first_fail_addr <= addr;
          first_fail_data <= read_data_mem;
        end
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_WR_P;
            rd_second       <= 1'b0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_addr <= '0;
            first_fail_data <= '0;
            MemWrite        <= 1'b1;
            MemRead         <= 1'b0;
          end
        end
        S_WR_P, S_WR_N: begin
          if (last) begin
            state    <= (state == S_WR_P) ? S_RD_P : S_RD_N;
            MemWrite <= 1'b0;
            MemRead  <= 1'b1;
          end
        end
        S_RD_P, S_RD_N: begin
          rd_second <= !rd_second;
          if (rd_second && last) begin
            MemRead <= 1'b0;
            if (state == S_RD_P) begin
              state    <= S_WR_N;
              MemWrite <= 1'b1;
            end else begin
              state <= S_DONE;
            end
          end
        end
        // final error count settles here before pass is latched
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bist.sv
// Bench for data_mem_bist: registered-read memory with fault injection,
// march reference model and done-triggered scoreboard.
module tb_data_mem_bist;

  typedef struct packed {
    int          cycles;
    int          scyc;
    logic [15:0] err;
    logic [15:0] ffa;
    logic [15:0] ffd;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_fail_addr;
  logic [15:0] first_fail_data;
  logic [15:0] address;
  logic [15:0] write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] read_data_mem;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q[$];

  logic [15:0] mem [0:65535];
  logic [15:0] rd_q = '0;
  int          fault_kind = 0;
  logic [15:0] f_addr = '0;
  logic [15:0] f_mask = '0;
  logic [15:0] al_src = '0;
  logic [15:0] al_dst = '0;

  data_mem_bist #(
    .BASE    (16'h0000),
    .DEPTH   (8),
    .PATTERN (16'hF0F0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr),
    .first_fail_data (first_fail_data),
    .address         (address),
    .write_data      (write_data),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .read_data_mem   (read_data_mem)
  );

  initial forever #10 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [15:0] phys(input logic [15:0] a);
    return (fault_kind == 2 && a == al_src) ? al_dst : a;
  endfunction

  always @(posedge clk) begin
    if (MemWrite) mem[phys(address)] <= write_data;
    if (MemRead)
      rd_q <= mem[phys(address)] |
              ((fault_kind == 1 && address == f_addr) ? f_mask : 16'h0);
  end
  assign read_data_mem = rd_q;

  // March over 8 words with the same fault model, expressed as phases.
  function automatic exp_t model(input int kind, input logic [15:0] fa,
                                 input logic [15:0] fm, input logic [15:0] as,
                                 input logic [15:0] ad);
    logic [15:0] m [0:7];
    logic [15:0] a, d, p, got;
    exp_t e;
    e = '0;
    for (int i = 0; i < 8; i++) m[i] = '0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 8; k++) begin
        a = (ph == 3) ? 16'(7 - k) : 16'(k);
        d = 16'hF0F0 ^ a;
        if (ph >= 2) d = ~d;
        p = (kind == 2 && a == as) ? ad : a;
        if (ph % 2 == 0) begin
          m[p[2:0]] = d;
        end else begin
          got = m[p[2:0]] | ((kind == 1 && a == fa) ? fm : 16'h0);
          if (got != d) begin
            if (e.err == 0) begin
              e.ffa = a;
              e.ffd = got;
            end
            e.err = e.err + 16'd1;
          end
        end
      end
    end
    e.pass = (e.err == 0);
    e.cycles = 6 * 8 + 1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic start_run(input exp_t e, input bit push);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) begin
      e.scyc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input bit extra);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      start = extra && (i == 5 || i == 20 || i == 40);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Scoreboard monitor: one expectation is consumed per done rise.
  initial begin
    exp_t e;
    logic dq;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !dq) begin
        if (q.size() == 0) begin
          chk("spurious_done", {31'd0, done}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - e.scyc, e.cycles);
          chk("err_count", {16'd0, err_count}, {16'd0, e.err});
          chk("ff_addr", {16'd0, first_fail_addr}, {16'd0, e.ffa});
          chk("ff_data", {16'd0, first_fail_data}, {16'd0, e.ffd});
          chk("pass", {31'd0, pass}, {31'd0, e.pass});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      dq = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int cnt;
    bit found;
    bit seen_rd;

    #15;
    chk("rst_ctl", {27'd0, busy, done, pass, MemWrite, MemRead}, 32'd0);
    chk("rst_err", {16'd0, err_count}, 32'd0);
    chk("rst_ffa", {16'd0, first_fail_addr}, 32'd0);
    chk("rst_ffd", {16'd0, first_fail_data}, 32'd0);
    chk("rst_addr", {16'd0, address}, 32'd0);
    chk("rst_wdata", {16'd0, write_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (MemWrite || MemRead) cnt++;
    end
    chk("idle_quiet", cnt, 0);

    // Clean run, extra start pulses while busy must not restart it.
    e = model(0, 0, 0, 0, 0);
    start_run(e, 1);
    wait_done(1);
    chk("mem2_end", {16'd0, mem[2]}, 32'h0F0D);

    // Stuck-at-1 on bit0 of word 5.
    fault_kind = 1;
    f_addr = 16'd5;
    f_mask = 16'h0001;
    e = '0;
    e.cycles = 49;
    e.err = 16'd1;
    e.ffa = 16'd5;
    e.ffd = 16'h0F0B;
    e.pass = 1'b0;
    start_run(e, 1);
    wait_done(0);

    // Address 6 aliased onto word 2.
    fault_kind = 2;
    al_src = 16'd6;
    al_dst = 16'd2;
    e = model(2, 0, 0, 16'd6, 16'd2);
    start_run(e, 1);
    wait_done(0);

    // Abort during the RD_P read of word 3.
    fault_kind = 0;
    start_run(e, 0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (MemRead && address == 16'd3) begin
        abort = 1'b1;
        found = 1'b1;
      end
    end
    if (!found) chk("abort_reach", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_mem", {30'd0, MemWrite, MemRead}, 32'd0);
    chk("abort_err", {16'd0, err_count}, 32'd0);
    abort = 1'b0;
    e = model(0, 0, 0, 0, 0);
    start_run(e, 1);
    wait_done(0);

    // Asynchronous reset in the middle of WR_N.
    start_run(e, 0);
    seen_rd = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (MemRead) seen_rd = 1'b1;
      if (seen_rd && MemWrite) found = 1'b1;
    end
    if (!found) chk("wrn_reach", {31'd0, found}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_ctl", {27'd0, busy, done, pass, MemWrite, MemRead}, 32'd0);
    chk("mr_addr", {16'd0, address}, 32'd0);
    chk("mr_wdata", {16'd0, write_data}, 32'd0);
    chk("mr_err", {16'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("mr_no_done", {31'd0, done}, 32'd0);

    // Randomized fault runs checked against the model.
    repeat (8) begin
      fault_kind = int'($urandom_range(0, 2));
      f_addr = 16'($urandom_range(0, 7));
      f_mask = 16'h0001 << $urandom_range(0, 15);
      al_src = 16'($urandom_range(0, 7));
      al_dst = 16'((al_src + $urandom_range(1, 7)) % 8);
      e = model(fault_kind, f_addr, f_mask, al_src, al_dst);
      start_run(e, 1);
      wait_done($urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
